obi_fetch_adapter: RTL and testbench

OBI_FETCH_ADAPTER -- requirements
Module: obi_fetch_adapter

---
 rtl/snitch_icache_pkg.sv | 12 +
 rtl/obi_fetch_port.sv | 133 +++++++++++++
 rtl/obi_fetch_adapter.sv | 57 +++++
 tb/tb_obi_fetch_adapter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_icache_pkg.sv
// rtl/snitch_icache_pkg.sv - shared types for the OBI instruction fetch adapter
package snitch_icache_pkg;

  localparam int unsigned StallCntWidth = 16;

  typedef enum logic [1:0] {
    FlushIdle  = 2'd0,
    FlushDrain = 2'd1,
    FlushDone  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/obi_fetch_port.sv
// rtl/obi_fetch_port.sv - one fetch port: request FIFO, response stage, flush FSM, stall counter
module obi_fetch_port
  import snitch_icache_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ReqDepth  = 2,
  parameter logic        RspCut    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic [AddrWidth-1:0]     addr_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [DataWidth-1:0]     rdata_o,
  output logic                     rerror_o,
  output logic                     inst_valid_o,
  output logic [AddrWidth-1:0]     inst_addr_o,
  input  logic                     inst_ready_i,
  input  logic [DataWidth-1:0]     inst_data_i,
  input  logic                     inst_error_i,
  input  logic                     flush_valid_i,
  output logic                     flush_ready_o,
  input  logic                     stall_clr_i,
  output logic [StallCntWidth-1:0] stall_cnt_o
);

  localparam int unsigned PtrW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
  localparam int unsigned CntW = $clog2(ReqDepth + 1);

  localparam logic [1:0] StIdle  = FlushIdle;
  localparam logic [1:0] StDrain = FlushDrain;
  localparam logic [1:0] StDone  = FlushDone;

  logic [AddrWidth-1:0]     mem_q [ReqDepth];
  logic [PtrW-1:0]          wptr_q, rptr_q;
  logic [CntW-1:0]          cnt_q;
  logic [1:0]               state_q, state_d;
  logic [StallCntWidth-1:0] stall_q;
  logic                     flush_pend, push, pop, rsp_pend;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(ReqDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A flush raised in the same cycle as a request already blocks that grant.
  assign flush_pend   = (state_q != StIdle) | flush_valid_i;
  assign gnt_o        = req_i & ~rst_i & (cnt_q < CntW'(ReqDepth)) & ~flush_pend;
  assign push         = gnt_o;
  assign inst_valid_o = (cnt_q != '0);
  assign inst_addr_o  = inst_valid_o ? mem_q[rptr_q] : '0;
  assign pop          = inst_valid_o & inst_ready_i & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= addr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  if (RspCut) begin : g_rsp_reg
    logic                 rv_q;
    logic [DataWidth-1:0] rd_q;
    logic                 re_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rv_q <= 1'b0;
        rd_q <= '0;
        re_q <= 1'b0;
      end else begin
        rv_q <= pop;
        if (pop) begin
          rd_q <= inst_data_i;
          re_q <= inst_error_i;
        end
      end
    end

    assign rvalid_o = rv_q & ~rst_i;
    assign rdata_o  = rd_q;
    assign rerror_o = re_q;
    assign rsp_pend = rv_q;
  end else begin : g_rsp_comb
    assign rvalid_o = pop;
    assign rdata_o  = pop ? inst_data_i : '0;
    assign rerror_o = pop & inst_error_i;
    assign rsp_pend = 1'b0;
  end

  // Drain completes only once nothing is queued and no registered response is still owed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (flush_valid_i) state_d = StDrain;
      StDrain: if ((cnt_q == '0) && !rsp_pend) state_d = StDone;
      StDone:  if (flush_valid_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  assign flush_ready_o = (state_q == StDone);

  always_ff @(posedge clk_i) begin
    if (rst_i || stall_clr_i) begin
      stall_q <= '0;
    end else if (inst_valid_o && !inst_ready_i && !(&stall_q)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_q;

endmodule

// File: rtl/obi_fetch_adapter.sv
// rtl/obi_fetch_adapter.sv - OBI fetch front end bridging NumPorts cores to instruction cache ports
module obi_fetch_adapter
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NumPorts  = 1,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ReqDepth  = 2,
  parameter logic        RspCut    = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [NumPorts-1:0]                     fetch_req_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]      fetch_addr_i,
  output logic [NumPorts-1:0]                     fetch_gnt_o,
  output logic [NumPorts-1:0]                     fetch_rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]      fetch_rdata_o,
  output logic [NumPorts-1:0]                     fetch_rerror_o,
  output logic [NumPorts-1:0]                     inst_valid_o,
  output logic [NumPorts-1:0][AddrWidth-1:0]      inst_addr_o,
  input  logic [NumPorts-1:0]                     inst_ready_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]      inst_data_i,
  input  logic [NumPorts-1:0]                     inst_error_i,
  input  logic [NumPorts-1:0]                     flush_valid_i,
  output logic [NumPorts-1:0]                     flush_ready_o,
  input  logic [NumPorts-1:0]                     stall_clr_i,
  output logic [NumPorts-1:0][StallCntWidth-1:0]  stall_cnt_o
);

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    obi_fetch_port #(
      .AddrWidth (AddrWidth),
      .DataWidth (DataWidth),
      .ReqDepth  (ReqDepth),
      .RspCut    (RspCut)
    ) i_port (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_i         (fetch_req_i[p]),
      .addr_i        (fetch_addr_i[p]),
      .gnt_o         (fetch_gnt_o[p]),
      .rvalid_o      (fetch_rvalid_o[p]),
      .rdata_o       (fetch_rdata_o[p]),
      .rerror_o      (fetch_rerror_o[p]),
      .inst_valid_o  (inst_valid_o[p]),
      .inst_addr_o   (inst_addr_o[p]),
      .inst_ready_i  (inst_ready_i[p]),
      .inst_data_i   (inst_data_i[p]),
      .inst_error_i  (inst_error_i[p]),
      .flush_valid_i (flush_valid_i[p]),
      .flush_ready_o (flush_ready_o[p]),
      .stall_clr_i   (stall_clr_i[p]),
      .stall_cnt_o   (stall_cnt_o[p])
    );
  end

endmodule

// File: tb/tb_obi_fetch_adapter.sv
// tb/tb_obi_fetch_adapter.sv - self-checking bench for obi_fetch_adapter (registered and combinational response)
module tb_obi_fetch_adapter;

  logic        clk = 1'b0;
  logic        rst, req, rdy, ierr, fv, clr;
  logic [31:0] addr, idata;

  logic        gnt_a, rv_a, re_a, iv_a, fr_a;
  logic [31:0] rd_a, ia_a;
  logic [15:0] sc_a;
  logic        gnt_b, rv_b, re_b, iv_b, fr_b;
  logic [31:0] rd_b, ia_b;
  logic [15:0] sc_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: pending addresses per instance, owed registered response, stall count, flush phase.
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  bit          rsp_v;
  logic [31:0] rsp_d;
  bit          rsp_e;
  int          sc [2];
  int          ph [2];

  always #5 clk = ~clk;

  obi_fetch_adapter #(.NumPorts(1), .AddrWidth(32), .DataWidth(32), .ReqDepth(2), .RspCut(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(req), .fetch_addr_i(addr), .fetch_gnt_o(gnt_a),
    .fetch_rvalid_o(rv_a), .fetch_rdata_o(rd_a), .fetch_rerror_o(re_a), .inst_valid_o(iv_a),
    .inst_addr_o(ia_a), .inst_ready_i(rdy), .inst_data_i(idata), .inst_error_i(ierr),
    .flush_valid_i(fv), .flush_ready_o(fr_a), .stall_clr_i(clr), .stall_cnt_o(sc_a));

  obi_fetch_adapter #(.NumPorts(1), .AddrWidth(32), .DataWidth(32), .ReqDepth(2), .RspCut(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst), .fetch_req_i(req), .fetch_addr_i(addr), .fetch_gnt_o(gnt_b),
    .fetch_rvalid_o(rv_b), .fetch_rdata_o(rd_b), .fetch_rerror_o(re_b), .inst_valid_o(iv_b),
    .inst_addr_o(ia_b), .inst_ready_i(rdy), .inst_data_i(idata), .inst_error_i(ierr),
    .flush_valid_i(fv), .flush_ready_o(fr_b), .stall_clr_i(clr), .stall_cnt_o(sc_b));

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [31:0] qfront(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    rsp_v = 0; rsp_d = '0; rsp_e = 0;
    sc[0] = 0; sc[1] = 0; ph[0] = 0; ph[1] = 0;
  endtask

  // Check every output of both instances against the reference, then advance the reference one clock.
  task automatic step();
    int          n;
    bit          iv, eg, pop, erv, ere, rv_old;
    logic [31:0] ia, erd;
    #1;
    rv_old = rsp_v;
    for (int k = 0; k < 2; k++) begin
      n   = qsize(k);
      iv  = (n != 0);
      ia  = iv ? qfront(k) : 32'h0;
      eg  = !rst && req && (n < 2) && (ph[k] == 0) && !fv;
      pop = iv && rdy && !rst;
      if (k == 0) begin
        erv = rv_old && !rst; erd = rsp_d; ere = rsp_e;
      end else begin
        erv = pop; erd = pop ? idata : 32'h0; ere = pop && ierr;
      end
      chk($sformatf("gnt[%0d]", k),    32'((k == 0) ? gnt_a : gnt_b), 32'(eg));
      chk($sformatf("ivalid[%0d]", k), 32'((k == 0) ? iv_a : iv_b),   32'(iv));
      chk($sformatf("iaddr[%0d]", k),  (k == 0) ? ia_a : ia_b,         ia);
      chk($sformatf("rvalid[%0d]", k), 32'((k == 0) ? rv_a : rv_b),   32'(erv));
      if (erv) begin
        chk($sformatf("rdata[%0d]", k),  (k == 0) ? rd_a : rd_b,         erd);
        chk($sformatf("rerror[%0d]", k), 32'((k == 0) ? re_a : re_b),   32'(ere));
      end
      chk($sformatf("fready[%0d]", k), 32'((k == 0) ? fr_a : fr_b),   32'(ph[k] == 2));
      chk($sformatf("stall[%0d]", k),  32'((k == 0) ? sc_a : sc_b),   32'(sc[k]));
      if (!rst) begin
        if (eg) begin
          if (k == 0) q0.push_back(addr); else q1.push_back(addr);
        end
        if (pop) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (k == 0) begin
          rsp_v = pop;
          if (pop) begin rsp_d = idata; rsp_e = ierr; end
        end
        if (clr) sc[k] = 0;
        else if (iv && !rdy && sc[k] < 65535) sc[k]++;
        case (ph[k])
          0: if (fv) ph[k] = 1;
          1: if (n == 0 && !(k == 0 && rv_old)) ph[k] = 2;
          default: if (fv) ph[k] = 0;
        endcase
      end
    end
    if (rst) model_reset();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_done;
    rst = 1; req = 0; addr = 0; rdy = 0; idata = 0; ierr = 0; fv = 0; clr = 0;
    model_reset();
    @(negedge clk);
    step();
    req = 1; addr = 32'h40;
    step();
    chk("reset gnt", 32'(gnt_a), 32'h0);
    chk("reset rdata", rd_a, 32'h0);
    chk("reset stall", 32'(sc_a), 32'h0);
    rst = 0; req = 0;
    step();

    // Back-to-back fetches with an always-ready cache.
    rdy = 1;
    req = 1; addr = 32'h100; idata = 32'h1000_0001; step();
    addr = 32'h104; idata = 32'h1000_0002; step();
    addr = 32'h108; idata = 32'h1000_0003; step();
    req = 0; idata = 32'h1000_0004; step();
    idata = 32'h1000_0005; step();
    step();

    // Held request against a stalled cache.
    rdy = 0; req = 1; addr = 32'h180;
    for (int i = 0; i < 6; i++) begin
      step();
      addr = addr + 4;
    end
    chk("stall count after 5 stalled cycles", 32'(sc_a), 32'd5);
    req = 0; rdy = 1;
    for (int i = 0; i < 4; i++) step();

    // Combinational response carries error and data in the pop cycle.
    rdy = 0; req = 1; addr = 32'h200; step();
    req = 0; rdy = 1; idata = 32'hDEADBEEF; ierr = 1;
    #1;
    chk("comb rvalid", 32'(rv_b), 32'h1);
    chk("comb rdata", rd_b, 32'hDEADBEEF);
    chk("comb rerror", 32'(re_b), 32'h1);
    step();
    ierr = 0; step();

    // Flush with two requests outstanding.
    rdy = 0; req = 1; addr = 32'h300; step();
    addr = 32'h304; step();
    fv = 1;
    for (int i = 0; i < 3; i++) step();
    rdy = 1;
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ph[0] == 2) seen_done = 1;
      if (seen_done && ph[0] == 0) break;
    end
    chk("flush handshake completed", 32'(seen_done && ph[0] == 0), 32'h1);
    fv = 0; addr = 32'h308;
    for (int i = 0; i < 3; i++) step();
    req = 0;
    for (int i = 0; i < 3; i++) step();

    // Stall counter saturation, then clear during a stall.
    rdy = 0; req = 1; addr = 32'h400; step();
    req = 0;
    for (int i = 0; i < 65540; i++) step();
    chk("stall saturated", 32'(sc_a), 32'h0000FFFF);
    clr = 1; step();
    clr = 0;
    chk("stall cleared", 32'(sc_a), 32'h0);
    rdy = 1; step(); step();

    // Reset with queued requests and an owed registered response.
    rdy = 0; req = 1; addr = 32'h500; step();
    addr = 32'h504; step();
    rdy = 1; addr = 32'h508; idata = 32'h5555_AAAA; step();
    rst = 1; req = 0; rdy = 0;
    step();
    chk("rst ivalid", 32'(iv_a), 32'h0);
    chk("rst rvalid", 32'(rv_a), 32'h0);
    chk("rst iaddr", ia_a, 32'h0);
    chk("rst rdata", rd_a, 32'h0);
    rst = 0;
    step();
    chk("post-rst ivalid", 32'(iv_a), 32'h0);
    chk("post-rst rvalid", 32'(rv_a), 32'h0);
    chk("post-rst fready", 32'(fr_a), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      req   = ($urandom_range(0, 3) != 0);
      addr  = $urandom & 32'hFFFF_FFFC;
      rdy   = ($urandom_range(0, 3) != 0);
      idata = $urandom;
      ierr  = ($urandom_range(0, 7) == 0);
      fv    = fv ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 29) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
